// File: rtl/switch_ctrl_pkg.sv
// Shared constants for the multi-channel switch controller: mode encodings,
// default sizing and the per-channel next-state rule.
package switch_ctrl_pkg;

    localparam int DEFAULT_CHANNELS        = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    localparam logic MODE_TOGGLE    = 1'b0;
    localparam logic MODE_MOMENTARY = 1'b1;

    // Momentary follows the upcoming debounced level; toggle flips only on an accepted press.
    function automatic logic next_switch(
        input logic mode_bit,
        input logic cur_switch,
        input logic stable_next,
        input logic press
    );
        if (mode_bit == MODE_MOMENTARY) begin
            return stable_next;
        end
        return cur_switch ^ press;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch channel: optional two-flop synchroniser (SWITCH_SYNC_EN), debounce
// counter and accepted level. Exposes the next accepted level and a press strobe.
module switch_debounce
    import switch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic stable_next,
    output logic rise
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sample;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

`ifdef SWITCH_SYNC_EN
    logic [1:0] sync_q, sync_d;

    assign sync_d = {sync_q[0], button_in};
    assign sample = sync_q[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end
`else
    assign sample = button_in;
`endif

    // Any sample that agrees with the accepted level restarts the run count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise     = 1'b0;
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sample;
            cnt_d    = '0;
            rise     = sample;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stable_next = stable_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/switch_toggle_ctrl.sv
// Multi-channel debounced switch controller with per-channel toggle/momentary
// mode and change pulses. Input synchroniser enabled by defining SWITCH_SYNC_EN.
module switch_toggle_ctrl
    import switch_ctrl_pkg::*;
#(
    parameter int CHANNELS        = DEFAULT_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button_in,
    input  logic [CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0] switch_out,
    output logic [CHANNELS-1:0] changed
);

    logic [CHANNELS-1:0] stable_next;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] switch_q, switch_d;
    logic [CHANNELS-1:0] changed_q, changed_d;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock       (clock),
                .reset       (reset),
                .button_in   (button_in[gi]),
                .stable_next (stable_next[gi]),
                .rise        (rise[gi])
            );
        end
    endgenerate

    // Switching to momentary resyncs to the debounced level on the next edge.
    always_comb begin
        switch_d = switch_q;
        for (int i = 0; i < CHANNELS; i++) begin
            switch_d[i] = next_switch(mode[i], switch_q[i], stable_next[i], rise[i]);
        end
        changed_d = switch_d ^ switch_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            switch_q  <= '0;
            changed_q <= '0;
        end else begin
            switch_q  <= switch_d;
            changed_q <= changed_d;
        end
    end

    assign switch_out = switch_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_switch_toggle_ctrl.sv
// Directed bench for switch_toggle_ctrl (4 channels, 16-cycle debounce);
// latency follows whether SWITCH_SYNC_EN is defined for the build.
module tb_switch_toggle_ctrl;

`ifdef SWITCH_SYNC_EN
    localparam int LAT = 18;
`else
    localparam int LAT = 16;
`endif

    logic       clock;
    logic       reset;
    logic [3:0] button_in;
    logic [3:0] mode;
    logic [3:0] switch_out;
    logic [3:0] changed;

    int checks;
    int passes;

    switch_toggle_ctrl #(
        .CHANNELS        (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button_in  (button_in),
        .mode       (mode),
        .switch_out (switch_out),
        .changed    (changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges, then settle on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        reset     = 1'b1;
        button_in = 4'b0000;
        mode      = 4'b0000;
        @(negedge clock);
        @(negedge clock);
        chk("reset_switch", switch_out, 4'b0000);
        chk("reset_changed", changed, 4'b0000);
        reset = 1'b0;

        // Toggle press on ch0, long hold, release, second press.
        button_in = 4'b0001;
        tick(LAT - 1);
        chk("t0_before_accept", switch_out, 4'b0000);
        tick(1);
        chk("t0_press_switch", switch_out, 4'b0001);
        chk("t0_press_changed", changed, 4'b0001);
        tick(1);
        chk("t0_pulse_end", changed, 4'b0000);
        tick(20);
        chk("t0_hold", switch_out, 4'b0001);
        button_in = 4'b0000;
        tick(LAT);
        chk("t0_release_switch", switch_out, 4'b0001);
        chk("t0_release_changed", changed, 4'b0000);
        tick(5);
        button_in = 4'b0001;
        tick(LAT);
        chk("t0_press2_switch", switch_out, 4'b0000);
        chk("t0_press2_changed", changed, 4'b0001);
        tick(1);
        chk("t0_press2_pulse_end", changed, 4'b0000);

        // Asynchronous reset mid-cycle with ch0 latched on and ch1 counting.
        button_in = 4'b0000;
        tick(LAT + 2);
        button_in = 4'b0001;
        tick(LAT);
        chk("pre_reset_on", switch_out, 4'b0001);
        button_in = 4'b0011;
        tick(8);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_switch", switch_out, 4'b0000);
        chk("async_reset_changed", changed, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        tick(LAT - 1);
        chk("post_reset_no_early", switch_out, 4'b0000);
        tick(1);
        chk("post_reset_reaccept", switch_out, 4'b0011);
        chk("post_reset_changed", changed, 4'b0011);
        button_in = 4'b0000;
        tick(LAT + 2);
        chk("post_reset_release", switch_out, 4'b0011);
        button_in = 4'b0011;
        tick(LAT);
        chk("clear01_switch", switch_out, 4'b0000);
        chk("clear01_changed", changed, 4'b0011);
        button_in = 4'b0000;
        tick(LAT + 2);
        chk("clear01_idle", switch_out | changed, 4'b0000);

        // Glitch of 15 samples on ch1 must be ignored entirely.
        button_in = 4'b0010;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            chk("glitch_quiet_hi", switch_out | changed, 4'b0000);
        end
        button_in = 4'b0000;
        for (int k = 0; k < LAT; k++) begin
            tick(1);
            chk("glitch_quiet_lo", switch_out | changed, 4'b0000);
        end

        // A 16-sample pulse is just long enough.
        button_in = 4'b0010;
        tick(16);
        button_in = 4'b0000;
        if (LAT > 16) tick(LAT - 16);
        chk("pulse16_switch", switch_out, 4'b0010);
        chk("pulse16_changed", changed, 4'b0010);
        tick(LAT + 2);
        chk("pulse16_after", switch_out, 4'b0010);
        button_in = 4'b0010;
        tick(LAT);
        chk("clear1_switch", switch_out, 4'b0000);
        button_in = 4'b0000;
        tick(LAT + 2);

        // Momentary ch2.
        mode      = 4'b0100;
        button_in = 4'b0100;
        tick(LAT - 1);
        chk("m2_before", switch_out, 4'b0000);
        tick(1);
        chk("m2_press_switch", switch_out, 4'b0100);
        chk("m2_press_changed", changed, 4'b0100);
        tick(1);
        chk("m2_pulse_end", changed, 4'b0000);
        tick(27);
        chk("m2_hold", switch_out, 4'b0100);
        button_in = 4'b0000;
        tick(LAT - 1);
        chk("m2_release_before", switch_out, 4'b0100);
        tick(1);
        chk("m2_release_switch", switch_out, 4'b0000);
        chk("m2_release_changed", changed, 4'b0100);
        tick(1);
        chk("m2_release_pulse_end", changed, 4'b0000);

        // Mode changes on ch3.
        mode      = 4'b1000;
        button_in = 4'b1000;
        tick(LAT);
        chk("ms3_press_switch", switch_out, 4'b1000);
        chk("ms3_press_changed", changed, 4'b1000);
        mode = 4'b0000;
        tick(1);
        chk("ms3_to_toggle_hold", switch_out, 4'b1000);
        button_in = 4'b0000;
        tick(LAT + 2);
        chk("ms3_toggle_release", switch_out, 4'b1000);
        mode = 4'b1000;
        tick(1);
        chk("ms3_to_mom_switch", switch_out, 4'b0000);
        chk("ms3_to_mom_changed", changed, 4'b1000);
        tick(1);
        chk("ms3_pulse_end", changed, 4'b0000);
        mode = 4'b0000;
        tick(3);
        chk("ms3_back_toggle_hold", switch_out | changed, 4'b0000);

        // All channels pressed together, mixed modes.
        mode      = 4'b1010;
        button_in = 4'b1111;
        tick(LAT - 1);
        chk("all_before", switch_out, 4'b0000);
        tick(1);
        chk("all_switch", switch_out, 4'b1111);
        chk("all_changed", changed, 4'b1111);
        tick(1);
        chk("all_pulse_end", changed, 4'b0000);
        chk("all_hold", switch_out, 4'b1111);
        button_in = 4'b0000;
        tick(LAT);
        chk("all_release_switch", switch_out, 4'b0101);
        chk("all_release_changed", changed, 4'b1010);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
